// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like bus (req/addr_ok/data_ok) between the
// instruction port (I) and the data port (D). A grant is held until the slave
// accepts it. Accepted requests are tracked in an in-order ID FIFO so that each
// data_ok is routed back to the port that owns it.
// Optional build macro: ARB_RR_EN (round-robin arbitration instead of D-over-I).
module sram_bus_arbiter #(
    parameter int unsigned OTS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_wstrb,
    input  logic [31:0] i_wdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata,
    output logic        busy
);

    localparam int unsigned PtrW = (OTS_DEPTH > 1) ? $clog2(OTS_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic {
        PortI = 1'b0,
        PortD = 1'b1
    } port_e;

    port_e            gnt;
    logic             gnt_req;
    logic             full;
    logic             push;
    logic             pop;
    port_e            head_id;

    logic             lock_vld_q, lock_vld_d;
    port_e            lock_id_q, lock_id_d;
    logic [CntW-1:0]  ots_cnt_q, ots_cnt_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    port_e            id_fifo_q [OTS_DEPTH];

`ifdef ARB_RR_EN
    port_e            last_gnt_q, last_gnt_d;
`endif

    // Grant selection: a locked grant wins over any priority decision.
    always_comb begin
        gnt     = PortI;
        gnt_req = 1'b0;
        if (lock_vld_q) begin
            gnt     = lock_id_q;
            gnt_req = (lock_id_q == PortD) ? d_req : i_req;
        end else if (d_req && i_req) begin
`ifdef ARB_RR_EN
            gnt = (last_gnt_q == PortD) ? PortI : PortD;
`else
            gnt = PortD;
`endif
            gnt_req = 1'b1;
        end else if (d_req) begin
            gnt     = PortD;
            gnt_req = 1'b1;
        end else if (i_req) begin
            gnt     = PortI;
            gnt_req = 1'b1;
        end
    end

    // Full check uses the registered count; a same-cycle pop does not free a slot.
    assign full    = (ots_cnt_q == CntW'(OTS_DEPTH));
    assign s_req   = gnt_req & ~full;
    assign s_wr    = (gnt == PortD) ? d_wr    : i_wr;
    assign s_size  = (gnt == PortD) ? d_size  : i_size;
    assign s_addr  = (gnt == PortD) ? d_addr  : i_addr;
    assign s_wstrb = (gnt == PortD) ? d_wstrb : i_wstrb;
    assign s_wdata = (gnt == PortD) ? d_wdata : i_wdata;

    assign push    = s_req & s_addr_ok;
    // A stray data_ok with nothing outstanding is dropped here.
    assign pop     = s_data_ok & (ots_cnt_q != '0);
    assign head_id = id_fifo_q[rd_ptr_q];

    assign i_addr_ok = push & (gnt == PortI);
    assign d_addr_ok = push & (gnt == PortD);
    assign i_data_ok = pop & (head_id == PortI);
    assign d_data_ok = pop & (head_id == PortD);
    assign i_rdata   = s_rdata;
    assign d_rdata   = s_rdata;
    assign busy      = (ots_cnt_q != '0) | lock_vld_q;

    // Next-state for lock, outstanding count and FIFO pointers.
    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        ots_cnt_d  = ots_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
`ifdef ARB_RR_EN
        last_gnt_d = last_gnt_q;
`endif
        if (s_req) begin
            lock_vld_d = ~s_addr_ok;
            if (!s_addr_ok) begin
                lock_id_d = gnt;
            end
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
`ifdef ARB_RR_EN
            last_gnt_d = gnt;
`endif
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   ots_cnt_d = ots_cnt_q + CntW'(1);
            2'b01:   ots_cnt_d = ots_cnt_q - CntW'(1);
            default: ots_cnt_d = ots_cnt_q;
        endcase
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_vld_q <= 1'b0;
            lock_id_q  <= PortI;
            ots_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
`ifdef ARB_RR_EN
            last_gnt_q <= PortI;
`endif
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            ots_cnt_q  <= ots_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
`ifdef ARB_RR_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    // ID FIFO storage; entries are only read when the count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            id_fifo_q[wr_ptr_q] <= gnt;
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Randomized bench for sram_bus_arbiter against a queue-based reference model.
// Honours ARB_RR_EN when the design is built with it.
module tb_sram_bus_arbiter;

    localparam int unsigned Depth  = 4;
    localparam int unsigned Cycles = 3000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0] i_rdata, d_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;
    logic        busy;

    // Requester state, index 0 = I, 1 = D.
    logic        req_v   [2];
    logic        wr_v    [2];
    logic [1:0]  size_v  [2];
    logic [31:0] addr_v  [2];
    logic [3:0]  wstrb_v [2];
    logic [31:0] wdata_v [2];
    logic        acc     [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: outstanding owners in order, plus the held grant if any.
    int q[$];
    bit m_locked;
    int m_lock_port;
    int m_last;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.OTS_DEPTH(Depth)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_req     (req_v[0]),
        .i_wr      (wr_v[0]),
        .i_size    (size_v[0]),
        .i_addr    (addr_v[0]),
        .i_wstrb   (wstrb_v[0]),
        .i_wdata   (wdata_v[0]),
        .i_addr_ok (i_addr_ok),
        .i_data_ok (i_data_ok),
        .i_rdata   (i_rdata),
        .d_req     (req_v[1]),
        .d_wr      (wr_v[1]),
        .d_size    (size_v[1]),
        .d_addr    (addr_v[1]),
        .d_wstrb   (wstrb_v[1]),
        .d_wdata   (wdata_v[1]),
        .d_addr_ok (d_addr_ok),
        .d_data_ok (d_data_ok),
        .d_rdata   (d_rdata),
        .s_req     (s_req),
        .s_wr      (s_wr),
        .s_size    (s_size),
        .s_addr    (s_addr),
        .s_wstrb   (s_wstrb),
        .s_wdata   (s_wdata),
        .s_addr_ok (s_addr_ok),
        .s_data_ok (s_data_ok),
        .s_rdata   (s_rdata),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) begin
                $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_locked    = 1'b0;
        m_lock_port = 0;
        m_last      = 0;
        acc[0]      = 1'b0;
        acc[1]      = 1'b0;
    endtask

    // Drive one cycle of stimulus, check outputs, then advance the model across the edge.
    task automatic cycle(input int req_pct, input int aok_pct, input int dok_pct,
                         input bit do_reset);
        int  gnt;
        bit  any, exp_sreq, exp_push, exp_pop;
        int  owner;
        for (int p = 0; p < 2; p++) begin
            if (acc[p]) req_v[p] = 1'b0;
            acc[p] = 1'b0;
            if (!req_v[p] && ($urandom_range(99) < req_pct)) begin
                req_v[p]   = 1'b1;
                wr_v[p]    = 1'($urandom);
                size_v[p]  = 2'($urandom_range(2));
                addr_v[p]  = $urandom;
                wstrb_v[p] = 4'($urandom);
                wdata_v[p] = $urandom;
            end
        end
        resetn    = !do_reset;
        s_addr_ok = ($urandom_range(99) < aok_pct);
        s_data_ok = ($urandom_range(99) < dok_pct);
        s_rdata   = $urandom;
        #3;
        if (do_reset) begin
            @(posedge clk);
            model_reset();
            #1;
            return;
        end

        if (m_locked) begin
            gnt = m_lock_port;
            any = req_v[gnt];
        end else begin
            any = req_v[0] || req_v[1];
            if (req_v[0] && req_v[1]) begin
`ifdef ARB_RR_EN
                gnt = 1 - m_last;
`else
                gnt = 1;
`endif
            end else begin
                gnt = req_v[1] ? 1 : 0;
            end
        end
        assert (!(m_locked && !req_v[m_lock_port]));
        exp_sreq = any && (q.size() < Depth);
        exp_push = exp_sreq && s_addr_ok;
        exp_pop  = s_data_ok && (q.size() > 0);
        owner    = exp_pop ? q[0] : -1;

        check_eq("s_req",     32'(s_req),     32'(exp_sreq));
        check_eq("i_addr_ok", 32'(i_addr_ok), 32'(exp_push && gnt == 0));
        check_eq("d_addr_ok", 32'(d_addr_ok), 32'(exp_push && gnt == 1));
        check_eq("i_data_ok", 32'(i_data_ok), 32'(owner == 0));
        check_eq("d_data_ok", 32'(d_data_ok), 32'(owner == 1));
        check_eq("busy",      32'(busy),      32'(q.size() != 0 || m_locked));
        check_eq("i_rdata",   i_rdata,        s_rdata);
        check_eq("d_rdata",   d_rdata,        s_rdata);
        if (exp_sreq) begin
            check_eq("s_addr",  s_addr,         addr_v[gnt]);
            check_eq("s_wdata", s_wdata,        wdata_v[gnt]);
            check_eq("s_wr",    32'(s_wr),      32'(wr_v[gnt]));
            check_eq("s_size",  32'(s_size),    32'(size_v[gnt]));
            check_eq("s_wstrb", 32'(s_wstrb),   32'(wstrb_v[gnt]));
        end

        if (exp_pop) void'(q.pop_front());
        if (exp_sreq) begin
            if (s_addr_ok) begin
                m_locked = 1'b0;
                q.push_back(gnt);
                m_last   = gnt;
                acc[gnt] = 1'b1;
            end else begin
                m_locked    = 1'b1;
                m_lock_port = gnt;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            req_v[p] = 1'b0; wr_v[p] = 1'b0; size_v[p] = '0;
            addr_v[p] = '0; wstrb_v[p] = '0; wdata_v[p] = '0;
        end
        s_addr_ok = 1'b0;
        s_data_ok = 1'b0;
        s_rdata   = '0;
        model_reset();
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        // Idle after reset, including a stray data_ok.
        cycle(0, 100, 100, 1'b0);
        for (int c = 0; c < Cycles; c++) begin
            if (c == 900 || c == 1700 || c == 2500) begin
                cycle(60, 50, 30, 1'b1);
            end else if (c < 800) begin
                cycle(50, 60, 40, 1'b0);
            end else if (c < 1600) begin
                cycle(70, 70, 10, 1'b0);
            end else if (c < 2400) begin
                cycle(30, 30, 60, 1'b0);
            end else begin
                cycle(90, 80, 35, 1'b0);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
